alu_step_ctrl: RTL and testbench
================================

# alu_step_ctrl

Tick-paced operation sequencer for the ALU. Accepts one operation request at a time, waits for the next rising edge of the slow clock from `clock_div`, and presents the latched operands and opcode to the combinational ALU. After a fixed settle window it captures the result and holds it behind a valid/ready handshake for the display/output stage. This lets a human-visible slow clock step the ALU while the whole design stays on the single fast clock.

## Interface
- `WIDTH`, 4: operand and result width in bits.
- `OP_W`, 3: opcode width.
- `SETTLE`, 2: cycles from ALU drive to result capture; legal range 1..15.
- `clock`  in  1  system clock; all state is updated on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `div_clock`  in  1  slow clock from `clock_div`; treated as an asynchronous level.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_op`  in  OP_W  opcode.
- `req_a`, `req_b`  in  WIDTH  operands.
- `alu_op`  out  OP_W  opcode driven to the ALU.
- `alu_a`, `alu_b`  out  WIDTH  operands driven to the ALU.
- `alu_result`  in  WIDTH  ALU result (combinational).
- `alu_carry`  in  1  ALU carry/flag.
- `res_valid`  out  1  captured result available.
- `res_ready`  in  1  consumer takes the result.
- `res_data`  out  WIDTH  captured result.
- `res_carry`  out  1  captured carry.
- `busy`  out  1  asserted whenever the state is not IDLE.

## Operation
- Tick detection:
  - Two flip-flop synchronizer `s0 <= div_clock`, `s1 <= s0`, followed by `prev <= s1`.
  - `tick = s1 & ~prev`.
  - All three flops reset to 0, so a `div_clock` that is high at reset release produces exactly one tick.
- The state machine has four states:
  - **IDLE**
    - `req_ready=1`.
    - On `req_valid`, latch `req_op`/`req_a`/`req_b` into the operand registers and go to WAIT_TICK.
  - **WAIT_TICK**
    - On `tick`, clear the settle counter and go to EXEC.
    - Otherwise remain in WAIT_TICK.
  - **EXEC**
    - Increment the settle counter each cycle.
    - When the counter reaches `SETTLE-1`, capture `alu_result`/`alu_carry` into `res_data`/`res_carry` and go to DONE.
  - **DONE**
    - `res_valid=1`.
    - On `res_ready`, go to IDLE.
- `alu_op`/`alu_a`/`alu_b` are driven continuously from the operand registers, which hold their value until the next accepted request.
- Ticks that arrive in IDLE, EXEC or DONE are dropped. They are not queued.
- `req_ready` is 0 in every state except IDLE, and `res_valid` is 0 in every state except DONE.
- `res_data`/`res_carry` keep their last captured value after DONE.
- No arithmetic is performed inside this block; all widths pass through unchanged.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready=1`.
  - `res_valid=0`, `busy=0`.
  - `res_data=0`, `res_carry=0`.
  - Operand registers 0, so `alu_op`/`alu_a`/`alu_b` are 0.
  - Settle counter 0; synchronizer flops 0.
- A request is accepted in the cycle where `req_valid & req_ready` is true; the state is WAIT_TICK from the next cycle.
- Tick latency:
  - `tick` is high for exactly one cycle, 2 clock edges after `div_clock` is sampled high.
  - The state is EXEC one cycle after `tick`.
- Capture: `res_valid` rises exactly `SETTLE` cycles after the first EXEC cycle.
- A tick in the same cycle as acceptance is ignored, because the state is still IDLE in that cycle.
- With `res_ready` held at 1, DONE lasts one cycle and `req_ready` returns on the following cycle. Back-to-back operations therefore need one new tick each.
- A `reset` in any state returns the block to IDLE on the next edge and discards the pending request and result; the `clock_div` counter is not affected.

## Structure
- Package `alu_ctrl_pkg` holds:
  - the state enum `ctrl_state_t` (IDLE, WAIT_TICK, EXEC, DONE);
  - the opcode localparams shared with the ALU;
  - the `SETTLE` maximum constant.
- Sub-module `tick_sync` contains the synchronizer and rising-edge detector (ports `clock`, `reset`, `div_clock`, `tick`). It is reused by any other block that paces off `clock_div`.

## Test plan
- **Reset state:** Assert reset for 3 cycles with `div_clock` toggling. Required: `req_ready=1`, `res_valid=0`, `busy=0`, and all ALU outputs 0.
- **Basic operation:**
  - Stimulus: `WIDTH=4`, `SETTLE=2`. Request op=ADD, a=5, b=9. Raise `div_clock` 10 cycles later. ALU model returns 4'hE, carry 0.
  - Required: `tick` 2 cycles after the raise, then `res_valid` 3 cycles after `tick`, with `res_data=4'hE`, `res_carry=0`.
- **Dropped tick:** Pulse `div_clock` while the block is IDLE, then issue a request. Required: no EXEC until the next `div_clock` rise.
- **Result backpressure:** Hold `res_ready=0` for 20 cycles. Required: `res_valid` and `res_data` stable, `req_ready=0`, and a new `req_valid` not accepted.
- **Reset during EXEC:** Assert reset during EXEC. Required: IDLE next cycle, `res_valid` never asserts, and the next request completes normally.
- **Overflow operation:** Request a=4'hF, b=1 (ADD) with the ALU reporting carry=1. Required: `res_data=0`, `res_carry=1`.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the tick-paced ALU sequencer and the ALU it drives.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    EXEC      = 2'd2,
    DONE      = 2'd3
  } ctrl_state_t;

  // Opcode encoding shared with the combinational ALU
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  localparam int SETTLE_MAX = 15;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/tick_sync.sv
// Brings the slow divided clock into the fast domain and emits a one-cycle pulse per rising edge.
module tick_sync (
  input  logic clock,
  input  logic reset,
  input  logic div_clock,
  output logic tick
);

  logic s0_q, s0_d;
  logic s1_q, s1_d;
  logic prev_q, prev_d;

  always_comb begin
    s0_d   = div_clock;
    s1_d   = s0_q;
    prev_d = s1_q;
  end

  // All zero on reset so a level already high at release still yields one tick
  always_ff @(posedge clock) begin
    if (reset) begin
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s0_q   <= s0_d;
      s1_q   <= s1_d;
      prev_q <= prev_d;
    end
  end

  assign tick = s1_q & ~prev_q;

endmodule

// File: rtl/alu_step_ctrl.sv
// Sequencer that steps one ALU operation per slow-clock tick and holds the result behind valid/ready.
module alu_step_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int OP_W   = 3,
  parameter int SETTLE = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             div_clock,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [OP_W-1:0]  alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             busy
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  logic tick;

  tick_sync u_tick_sync (
    .clock     (clock),
    .reset     (reset),
    .div_clock (div_clock),
    .tick      (tick)
  );

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_carry_q, res_carry_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    req_ready   = 1'b0;
    res_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          state_d = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = EXEC;
        end
      end
      // ALU inputs are stable throughout EXEC; sample on the last settle cycle
      EXEC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SETTLE_LAST) begin
          res_data_d  = alu_result;
          res_carry_d = alu_carry;
          state_d     = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
    end
  end

  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_step_ctrl.sv
// Scoreboard bench for alu_step_ctrl with a small behavioural ALU on its outputs.
module tb_alu_step_ctrl;
  import alu_ctrl_pkg::*;

  localparam int WIDTH  = 4;
  localparam int OP_W   = 3;
  localparam int SETTLE = 2;
  // div_clock set after an edge -> res_valid visible after this many further edges
  localparam int RES_LAT = 3 + SETTLE;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             div_clock = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [OP_W-1:0]  req_op = '0;
  logic [WIDTH-1:0] req_a = '0;
  logic [WIDTH-1:0] req_b = '0;
  logic [OP_W-1:0]  alu_op;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_data;
  logic             res_carry;
  logic             busy;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [WIDTH:0] sb_q[$];

  always #5 clock = ~clock;

  alu_step_ctrl #(.WIDTH(WIDTH), .OP_W(OP_W), .SETTLE(SETTLE)) dut (
    .clock      (clock),
    .reset      (reset),
    .div_clock  (div_clock),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_carry  (res_carry),
    .busy       (busy)
  );

  // External combinational ALU stand-in
  logic [WIDTH:0] alu_full;
  always_comb begin
    alu_full = '0;
    case (alu_op)
      OP_ADD:  alu_full = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB:  alu_full = {1'b0, alu_a} - {1'b0, alu_b};
      OP_AND:  alu_full = {1'b0, alu_a & alu_b};
      default: alu_full = {1'b0, alu_a ^ alu_b};
    endcase
  end
  assign alu_result = alu_full[WIDTH-1:0];
  assign alu_carry  = alu_full[WIDTH];

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_request(input logic [OP_W-1:0] op, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_d,
                              input logic exp_c);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_accept: req_ready=%b required 1", req_ready);
    end
    sb_q.push_back({exp_c, exp_d});
    step(1);
    req_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || alu_op !== op || alu_a !== a || alu_b !== b) begin
      n_fail++;
      $display("FAIL req_latch: busy=%b op=%0d a=%h b=%h required busy=1 op=%0d a=%h b=%h",
               busy, alu_op, alu_a, alu_b, op, a, b);
    end
  endtask

  // Raise div_clock now and wait for res_valid; checks the exact latency
  task automatic tick_and_wait_valid();
    int n;
    n = 0;
    div_clock = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (res_valid === 1'b1) begin
        n = i;
        break;
      end
    end
    n_cmp++;
    if (n != RES_LAT) begin
      n_fail++;
      $display("FAIL res_latency: res_valid after %0d edges required %0d (0 = timeout)", n, RES_LAT);
    end
  endtask

  task automatic pop_result();
    logic [WIDTH:0] exp;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty: result data=%h carry=%b with no expectation", res_data, res_carry);
    end else begin
      exp = sb_q.pop_front();
      if (res_valid !== 1'b1 || {res_carry, res_data} !== exp) begin
        n_fail++;
        $display("FAIL result: valid=%b carry=%b data=%h required valid=1 carry=%b data=%h",
                 res_valid, res_carry, res_data, exp[WIDTH], exp[WIDTH-1:0]);
      end
    end
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || {res_carry, res_data} !== exp) begin
      n_fail++;
      $display("FAIL release: valid=%b ready=%b busy=%b carry=%b data=%h required 0 1 0 %b %h",
               res_valid, req_ready, busy, res_carry, res_data, exp[WIDTH], exp[WIDTH-1:0]);
    end
    div_clock = 1'b0;
    step(3);
  endtask

  task automatic run_op(input logic [OP_W-1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_d,
                        input logic exp_c);
    send_request(op, a, b, exp_d, exp_c);
    step(3);
    tick_and_wait_valid();
    pop_result();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      div_clock = ~div_clock;
      step(1);
    end
    n_cmp++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 ||
        alu_op !== '0 || alu_a !== '0 || alu_b !== '0 || res_data !== '0 || res_carry !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: rr=%b rv=%b busy=%b op=%0d a=%h b=%h d=%h c=%b required 1 0 0 0 0 0 0 0",
               req_ready, res_valid, busy, alu_op, alu_a, alu_b, res_data, res_carry);
    end
    reset = 1'b0;
    div_clock = 1'b0;
    step(4);
    n_cmp++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy=%b rr=%b rv=%b required 0 1 0", busy, req_ready, res_valid);
    end
  endtask

  task automatic test_basic();
    int early;
    early = 0;
    send_request(OP_ADD, 4'd5, 4'd9, 4'hE, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (res_valid !== 1'b0 || busy !== 1'b1) early++;
      step(1);
    end
    n_cmp++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL basic_wait: %0d cycles with result/idle before tick, required 0", early);
    end
    tick_and_wait_valid();
    pop_result();
  endtask

  task automatic test_dropped_tick();
    int early;
    early = 0;
    div_clock = 1'b1;
    step(2);
    div_clock = 1'b0;
    step(4);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_idle: busy=%b required 0", busy);
    end
    send_request(OP_SUB, 4'd9, 4'd3, 4'h6, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (res_valid !== 1'b0) early++;
      step(1);
    end
    n_cmp++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL drop_queued: res_valid high %0d cycles without tick, required 0", early);
    end
    tick_and_wait_valid();
    pop_result();
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    send_request(OP_AND, 4'hC, 4'hA, 4'h8, 1'b0);
    step(2);
    tick_and_wait_valid();
    req_op = OP_XOR; req_a = 4'h3; req_b = 4'h5; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (res_valid !== 1'b1 || res_data !== 4'h8 || req_ready !== 1'b0 ||
          alu_a !== 4'hC || alu_op !== OP_AND) bad++;
    end
    req_valid = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL backpressure: %0d unstable/accepting cycles, required 0 (data=%h rr=%b)",
               bad, res_data, req_ready);
    end
    pop_result();
  endtask

  task automatic test_reset_exec();
    int seen;
    seen = 0;
    send_request(OP_ADD, 4'd3, 4'd4, 4'h7, 1'b0);
    step(2);
    div_clock = 1'b1;
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    div_clock = 1'b0;
    void'(sb_q.pop_back());
    n_cmp++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || res_valid !== 1'b0 || alu_a !== '0) begin
      n_fail++;
      $display("FAIL reset_exec: busy=%b rr=%b rv=%b a=%h required 0 1 0 0",
               busy, req_ready, res_valid, alu_a);
    end
    for (int i = 0; i < 8; i++) begin
      if (res_valid !== 1'b0) seen++;
      step(1);
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_exec_valid: res_valid high %0d cycles, required 0", seen);
    end
    run_op(OP_ADD, 4'd2, 4'd6, 4'h8, 1'b0);
  endtask

  task automatic test_overflow();
    run_op(OP_ADD, 4'hF, 4'h1, 4'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_op(OP_SUB, 4'h2, 4'h5, 4'hD, 1'b1);
    run_op(OP_XOR, 4'hA, 4'h6, 4'hC, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dropped_tick();
    test_backpressure();
    test_reset_exec();
    test_overflow();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
